sr_cmd_sequencer: RTL and testbench

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

---
 rtl/sr_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_sequencer.sv
// Queued SET/CLR command sequencer driving a downstream SR flop with timed pulses and a shadow of its q.
// Define SR_CMD_TOGGLE_EN to execute TOGGLE from the shadow; otherwise every popped TOGGLE is dropped with err.
module sr_cmd_sequencer #(
    parameter int DEPTH     = 4,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    output logic       s,
    output logic       r,
    output logic       shadow_q,
    output logic       shadow_vld,
    output logic       busy,
    output logic       err
);

    // state | meaning
    // IDLE  | no pulse in flight; pops one command per cycle when the FIFO is non-empty
    // DRIVE | s or r held high for PULSE_CYC cycles
    // GAP   | forced s=r=0 for GAP_CYC cycles before the next pop
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_TOG = 2'b11;

    localparam int AW      = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = (GAP_CYC == 0) ? '0 : CW'(GAP_CYC - 1);

    logic [1:0]  fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;
    logic [1:0]  head_op;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           s_nxt, r_nxt, err_nxt, shadow_q_nxt, shadow_vld_nxt;
    logic           do_set, do_clr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head_op    = fifo_mem[rd_ptr[AW-1:0]];
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= cmd_op;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pop            = 1'b0;
        s_nxt          = 1'b0;
        r_nxt          = 1'b0;
        err_nxt        = 1'b0;
        shadow_q_nxt   = shadow_q;
        shadow_vld_nxt = shadow_vld;
        do_set         = 1'b0;
        do_clr         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head_op)
                        OP_SET: do_set = 1'b1;
                        OP_CLR: do_clr = 1'b1;
                        OP_TOG: begin
`ifdef SR_CMD_TOGGLE_EN
                            if (shadow_vld) begin
                                do_set = !shadow_q;
                                do_clr = shadow_q;
                            end else begin
                                err_nxt = 1'b1;
                            end
`else
                            err_nxt = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                    if (do_set || do_clr) begin
                        state_nxt      = ST_DRIVE;
                        cnt_nxt        = PULSE_LD;
                        s_nxt          = do_set;
                        r_nxt          = do_clr;
                        shadow_q_nxt   = do_set;
                        shadow_vld_nxt = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    if (GAP_CYC == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LD;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    s_nxt   = s;
                    r_nxt   = r;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            s          <= 1'b0;
            r          <= 1'b0;
            err        <= 1'b0;
            shadow_q   <= 1'b0;
            shadow_vld <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            s          <= s_nxt;
            r          <= r_nxt;
            err        <= err_nxt;
            shadow_q   <= shadow_q_nxt;
            shadow_vld <= shadow_vld_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: instance 0 uses default timing, instance 1 uses PULSE_CYC=3, GAP_CYC=2.
module tb_sr_cmd_sequencer;

    localparam logic [1:0] NOP = 2'b00, CLR = 2'b01, SET = 2'b10, TOG = 2'b11;
    localparam int K_S = 0, K_R = 1, K_E = 2;

    typedef struct {
        int inst;
        int kind;
        int len;
    } ev_t;

    logic       clk, reset;
    logic       cmd_valid [2];
    logic [1:0] cmd_op    [2];
    logic       cmd_ready [2];
    logic       s_o       [2];
    logic       r_o       [2];
    logic       shq       [2];
    logic       shv       [2];
    logic       busy      [2];
    logic       err_o     [2];

    int   checks = 0;
    int   errors = 0;
    int   overlap = 0;
    int   run_len [2][3];
    ev_t  exp_q[$];
    logic m_sh_q [2];
    logic m_sh_v [2];

    sr_cmd_sequencer #(.DEPTH(4), .PULSE_CYC(1), .GAP_CYC(1)) u0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .s(s_o[0]), .r(r_o[0]), .shadow_q(shq[0]),
        .shadow_vld(shv[0]), .busy(busy[0]), .err(err_o[0]));

    sr_cmd_sequencer #(.DEPTH(4), .PULSE_CYC(3), .GAP_CYC(2)) u1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .s(s_o[1]), .r(r_o[1]), .shadow_q(shq[1]),
        .shadow_vld(shv[1]), .busy(busy[1]), .err(err_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: order of execution equals order of acceptance, so the shadow
    // can be predicted at push time and the resulting pulse queued.
    function automatic void model_cmd(input int i, input logic [1:0] op);
        int plen;
        plen = (i == 0) ? 1 : 3;
        case (op)
            SET: begin exp_q.push_back('{i, K_S, plen}); m_sh_q[i] = 1'b1; m_sh_v[i] = 1'b1; end
            CLR: begin exp_q.push_back('{i, K_R, plen}); m_sh_q[i] = 1'b0; m_sh_v[i] = 1'b1; end
            TOG: begin
`ifdef SR_CMD_TOGGLE_EN
                if (m_sh_v[i]) begin
                    exp_q.push_back('{i, m_sh_q[i] ? K_R : K_S, plen});
                    m_sh_q[i] = !m_sh_q[i];
                end else begin
                    exp_q.push_back('{i, K_E, 1});
                end
`else
                exp_q.push_back('{i, K_E, 1});
`endif
            end
            default: ;
        endcase
    endfunction

    task automatic send(input int i, input logic [1:0] op, input bit model, output int held);
        held = 0;
        cmd_valid[i] = 1'b1;
        cmd_op[i]    = op;
        while (!cmd_ready[i] && held < 50) begin
            tick;
            held++;
        end
        if (held >= 50) chk("send_ready_timeout", held, 0);
        if (model) model_cmd(i, op);
        tick;
        cmd_valid[i] = 1'b0;
        cmd_op[i]    = NOP;
    endtask

    task automatic wait_idle(input int i);
        for (int n = 0; n < 300; n++) begin
            if (!busy[i]) break;
            tick;
        end
        chk("drain", busy[i], 0);
    endtask

    // Pulse monitor: every completed s/r/err run is popped against the scoreboard.
    always @(posedge clk) begin
        logic [2:0] chan;
        ev_t        e;
        #1;
        for (int i = 0; i < 2; i++) begin
            chan = {err_o[i], r_o[i], s_o[i]};
            for (int k = 0; k < 3; k++) begin
                if (chan[k] === 1'b1) begin
                    run_len[i][k]++;
                end else if (run_len[i][k] != 0) begin
                    chk("event_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("event_inst_kind_len", i * 1000 + k * 100 + run_len[i][k],
                            e.inst * 1000 + e.kind * 100 + e.len);
                    end
                    run_len[i][k] = 0;
                end
            end
            if (s_o[i] === 1'b1 && r_o[i] === 1'b1) overlap++;
        end
    end

    initial begin
        int held;
        int s_cnt, r_cnt, low_mid;
        bit seen_s, seen_r;
        logic sh_before;

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) run_len[i][k] = 0;
            m_sh_q[i] = 1'b0;
            m_sh_v[i] = 1'b0;
            cmd_valid[i] = 1'b0;
            cmd_op[i] = NOP;
        end

        // Reset with a command offered: it must be ignored.
        reset = 1'b1;
        cmd_valid[0] = 1'b1;
        cmd_op[0] = SET;
        tick;
        tick;
        for (int i = 0; i < 2; i++) begin
            chk("rst_s", s_o[i], 0);
            chk("rst_r", r_o[i], 0);
            chk("rst_err", err_o[i], 0);
            chk("rst_shq", shq[i], 0);
            chk("rst_shv", shv[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_ready", cmd_ready[i], 1);
        end
        reset = 1'b0;
        cmd_valid[0] = 1'b0;
        cmd_op[0] = NOP;

        // Cycle 2: SET pushed; pop in 3; s only in 4.
        send(0, SET, 1, held);
        chk("set_c3_s", s_o[0], 0);
        chk("set_c3_busy", busy[0], 1);
        tick;
        chk("set_c4_s", s_o[0], 1);
        chk("set_c4_r", r_o[0], 0);
        chk("set_c4_shq", shq[0], 1);
        chk("set_c4_shv", shv[0], 1);
        tick;
        chk("set_c5_s", s_o[0], 0);
        tick;
        chk("set_c6_busy", busy[0], 0);

        // NOP: consumed in one IDLE cycle, no shadow change.
        sh_before = shq[0];
        send(0, NOP, 1, held);
        tick;
        chk("nop_busy", busy[0], 0);
        chk("nop_shq", shq[0], sh_before);

        // Fill the FIFO while a long pulse keeps the FSM away from IDLE.
        send(1, SET, 1, held);
        tick;
        send(1, CLR, 1, held);
        send(1, SET, 1, held);
        send(1, CLR, 1, held);
        send(1, NOP, 1, held);
        chk("full_ready", cmd_ready[1], 0);
        send(1, SET, 1, held);
        chk("fifth_held", held, 2);
        wait_idle(1);
        chk("fill_shq", shq[1], m_sh_q[1]);

        // SET then CLR with PULSE_CYC=3, GAP_CYC=2 (plus the IDLE pop cycle).
        send(1, SET, 1, held);
        send(1, CLR, 1, held);
        s_cnt = 0; r_cnt = 0; low_mid = 0; seen_s = 0; seen_r = 0;
        for (int n = 0; n < 40; n++) begin
            if (s_o[1]) begin s_cnt++; seen_s = 1; end
            if (r_o[1]) begin r_cnt++; seen_r = 1; end
            if (seen_s && !seen_r && !s_o[1] && !r_o[1]) low_mid++;
            if (!busy[1]) break;
            tick;
        end
        chk("long_s_cycles", s_cnt, 3);
        chk("long_r_cycles", r_cnt, 3);
        chk("long_low_between", low_mid, 3);
        chk("long_busy", busy[1], 0);
        chk("long_shq", shq[1], 0);

        // Reset during the second DRIVE cycle with two commands queued.
        send(1, SET, 0, held);
        send(1, CLR, 0, held);
        send(1, SET, 0, held);
        exp_q.push_back('{1, K_S, 2});
        chk("abort_pre_s", s_o[1], 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_s", s_o[1], 0);
        chk("abort_busy", busy[1], 0);
        chk("abort_ready", cmd_ready[1], 1);
        chk("abort_shv", shv[1], 0);
        for (int i = 0; i < 2; i++) begin
            m_sh_q[i] = 1'b0;
            m_sh_v[i] = 1'b0;
        end
        repeat (10) tick;
        chk("abort_no_replay", busy[1], 0);

        // TOGGLE with an unknown shadow is dropped in every build.
        send(0, TOG, 1, held);
        chk("tog_pop_err", err_o[0], 0);
        tick;
        chk("tog_err", err_o[0], 1);
        chk("tog_s", s_o[0], 0);
        chk("tog_r", r_o[0], 0);
        chk("tog_busy", busy[0], 0);
        tick;
        chk("tog_err_end", err_o[0], 0);

        // SET then TOGGLE: CLR pulse with toggle support, err pulse without.
        send(0, SET, 1, held);
        send(0, TOG, 1, held);
        wait_idle(0);
        repeat (3) tick;
        chk("set_tog_shq", shq[0], m_sh_q[0]);
        chk("set_tog_shv", shv[0], 1);

        repeat (3) tick;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("s_r_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
